sprite_renderer: RTL and testbench
==================================

// Module: sprite_renderer
// PURPOSE
//  Parametrised tile-grid sprite renderer for the VGA plot path. It sits between the game
//  logic, the background ROM, the sprite ROM and the VGA adapter. It paints the full
//  background on the first frame and whenever a repaint is requested. On every other frame
//  it erases only the sprites that moved, then redraws all NUM_SPR sprites in index order
//  (higher index on top). Each pixel is emitted as a single-cycle plot strobe.
// PARAMETERS
//  NUM_SPR   4    number of sprites; index 0 comes from the sprite ROM, the rest use SPR_FLAT colour
//  TILE      5    tile edge in pixels
//  GRID_W    32   grid columns (SCREEN_W = GRID_W*TILE = 160)
//  GRID_H    24   grid rows (SCREEN_H = GRID_H*TILE = 120)
//  READ_LAT  1    synchronous ROM read latency, in cycles; applies to both ROMs, range 1..3
//  SPR_FLAT  12'hFFF  colour of sprites 1..NUM_SPR-1
// PORTS
//  clock      in   1          system clock
//  reset      in   1          asynchronous, active-high reset
//  start      in   1          begin one frame; ignored while busy
//  force_fill in   1          sampled with start: this frame does a full background paint
//  busy       out  1          high from the cycle after an accepted start until done
//  done       out  1          one-cycle pulse after the last plot of a frame
//  spr_gx     in   NUM_SPR*GXW  packed sprite columns, GXW=$clog2(GRID_W); sprite i at [i*GXW+:GXW]
//  spr_gy     in   NUM_SPR*GYW  packed sprite rows, GYW=$clog2(GRID_H)
//  bg_x       out  8          background ROM x address
//  bg_y       out  7          background ROM y address
//  bg_color   in   12         background pixel, valid READ_LAT cycles after bg_x/bg_y
//  spr_addr   out  $clog2(TILE*TILE)  sprite ROM address = dy*TILE+dx
//  spr_color  in   12         sprite pixel, valid READ_LAT cycles after spr_addr
//  vga_x      out  8          plot x
//  vga_y      out  7          plot y
//  vga_color  out  12         plot colour
//  vga_plot   out  1          plot strobe; x, y and colour are valid only while it is high
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; first_frame=1; previous-position registers 0.
//  States: IDLE -> LATCH -> (FILL if first_frame|force_fill) -> ERASE -> DRAW -> DRAIN -> IDLE.
//  LATCH, one cycle: snapshot spr_gx/spr_gy into cur[]. Inputs may change mid-frame without effect.
//  FILL: scan x=0..SCREEN_W-1 inner, y=0..SCREEN_H-1 outer, one address per cycle. At the end,
//   clear first_frame and go straight to DRAW; ERASE is skipped because the background is fresh.
//  ERASE: for each i with cur[i]!=prev[i], scan TILE*TILE pixels at prev[i], coloured from
//   bg_color. Sprites that did not move cost zero cycles. If no sprite moved, ERASE takes zero cycles.
//  DRAW: for each i in 0..NUM_SPR-1, scan TILE*TILE pixels at cur[i].
//   Sprite 0 takes spr_color; the others take SPR_FLAT. When the last pixel is issued, prev[]<=cur[].
//  Scan order within a tile: dx inner, dy outer. Pixel x = gx*TILE+dx, y = gy*TILE+dy.
//   Compute in 9/8 bits, then truncate to 8/7 bits. Coordinates are not clipped; off-screen
//   positions are a caller error.
//  Pipeline: vga_x, vga_y and the colour select travel through a READ_LAT-deep delay line
//   alongside the address. vga_plot is asserted exactly READ_LAT+1 cycles after an address issue.
//   There is no bubble between phases or sprites. DRAIN waits until the delay line is empty.
//  done pulses in the cycle after the final vga_plot; busy falls in the same cycle.
//  Cycle counts: full frame = 2 + SCREEN_W*SCREEN_H + NUM_SPR*TILE^2 + READ_LAT + 1.
//   Incremental frame = 2 + (moved+NUM_SPR)*TILE^2 + READ_LAT + 1.
//  A start pulse received while busy is dropped. A start held high re-triggers from IDLE.
//  Reset asserted mid-frame aborts immediately, clears vga_plot and sets first_frame=1,
//   so the next frame does a full fill.
//  Overlap: a later draw overwrites an earlier one; an erase may blank part of a sprite
//   drawn in the previous frame, and the DRAW phase repairs it.
// CONFIGURATION
//  `SPR_COLOR_KEY_EN defined: during DRAW, any pixel whose colour equals SPR_KEY (12'h000,
//   a localparam in the package) is suppressed: vga_plot stays 0 for that slot, and the
//   pipeline timing is unchanged. The background shows through.
//  `SPR_COLOR_KEY_EN undefined: every DRAW pixel is plotted, including the key colour.
// STRUCTURE
//  Package renderer_pkg: state enum (IDLE, LATCH, FILL, ERASE, DRAW, DRAIN), SPR_KEY, and the
//   COLOR_W=12, VX_W=8 and VY_W=7 constants.
//  Sub-module renderer_pixel_pipe #(READ_LAT): delay line for {x, y, plot, sel_sprite_rom, flat}.
//   The top level muxes the colour from its output.
//  Top level: FSM, the tile/scan counters, the cur[] and prev[] arrays, and the moved-sprite skip logic.
// TESTING
//  1. Reset, then start with spr=(0,0),(1,0),(2,0),(3,0). Expect a FILL of 19200 plots, x/y
//     raster-ordered, colour == bg model, then 100 DRAW plots; done once; total cycles per the formula.
//  2. Second start, positions unchanged. Expect no ERASE plots, 100 DRAW plots, and
//     done at cycle 2+100+READ_LAT+1.
//  3. Move sprite 2 to (5,7). Expect 25 erase plots over x=10..14, y=0..4 with bg colour,
//     then 100 DRAW plots; sprite 2 lands at x=25..29, y=35..39 in colour 12'hFFF.
//  4. Assert reset at cycle 500 of a FILL. vga_plot must drop in the same cycle. The next start
//     must do a full fill, regardless of force_fill.
//  5. Pulse start again while busy; it must be ignored, with no extra done.
//     Start with force_fill=1 on an incremental frame: the frame must do a full fill.
//  6. With `SPR_COLOR_KEY_EN defined and sprite ROM word 12 = 12'h000, pixel (dx=2, dy=2)
//     of sprite 0 must not be plotted. Without the macro, it is plotted as 12'h000.

Source files
------------

// File: rtl/renderer_pkg.sv
// Shared types and constants for the tile-grid sprite renderer.
package renderer_pkg;

  localparam int COLOR_W = 12;
  localparam int VX_W    = 8;
  localparam int VY_W    = 7;

  localparam logic [COLOR_W-1:0] SPR_KEY = 12'h000;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    FILL,
    ERASE,
    DRAW,
    DRAIN
  } state_t;

endpackage

// File: rtl/renderer_pixel_pipe.sv
// Delay line that carries plot coordinates and colour-source selects alongside
// the ROM read latency, so they emerge together with the ROM data.
module renderer_pixel_pipe
  import renderer_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [VX_W-1:0] x_p0,
  input  logic [VY_W-1:0] y_p0,
  input  logic            vld_p0,
  input  logic            sel_p0,
  input  logic            flat_p0,
  output logic [VX_W-1:0] x_p1,
  output logic [VY_W-1:0] y_p1,
  output logic            vld_p1,
  output logic            sel_p1,
  output logic            flat_p1
);

  logic [VX_W-1:0] x_dl   [READ_LAT];
  logic [VY_W-1:0] y_dl   [READ_LAT];
  logic [2:0]      ctl_dl [READ_LAT];

  always_ff @(posedge clock) begin
    x_dl[0] <= x_p0;
    y_dl[0] <= y_p0;
    for (int k = 1; k < READ_LAT; k++) begin
      x_dl[k] <= x_dl[k-1];
      y_dl[k] <= y_dl[k-1];
    end
  end

  // Strobe and selects are cleared on reset so an aborted frame leaves no plots in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < READ_LAT; k++) ctl_dl[k] <= '0;
    end else begin
      ctl_dl[0] <= {vld_p0, sel_p0, flat_p0};
      for (int k = 1; k < READ_LAT; k++) ctl_dl[k] <= ctl_dl[k-1];
    end
  end

  assign x_p1    = x_dl[READ_LAT-1];
  assign y_p1    = y_dl[READ_LAT-1];
  assign vld_p1  = ctl_dl[READ_LAT-1][2];
  assign sel_p1  = ctl_dl[READ_LAT-1][1];
  assign flat_p1 = ctl_dl[READ_LAT-1][0];

endmodule

// File: rtl/sprite_renderer.sv
// Tile-grid sprite renderer: full background fill or moved-sprite erase, then sprite redraw.
// Optional SPR_COLOR_KEY_EN suppresses DRAW pixels whose colour equals SPR_KEY.
module sprite_renderer
  import renderer_pkg::*;
#(
  parameter int                  NUM_SPR  = 4,
  parameter int                  TILE     = 5,
  parameter int                  GRID_W   = 32,
  parameter int                  GRID_H   = 24,
  parameter int                  READ_LAT = 1,
  parameter logic [COLOR_W-1:0]  SPR_FLAT = 12'hFFF
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   force_fill,
  output logic                                   busy,
  output logic                                   done,
  input  logic [NUM_SPR*$clog2(GRID_W)-1:0]      spr_gx,
  input  logic [NUM_SPR*$clog2(GRID_H)-1:0]      spr_gy,
  output logic [VX_W-1:0]                        bg_x,
  output logic [VY_W-1:0]                        bg_y,
  input  logic [COLOR_W-1:0]                     bg_color,
  output logic [$clog2(TILE*TILE)-1:0]           spr_addr,
  input  logic [COLOR_W-1:0]                     spr_color,
  output logic [VX_W-1:0]                        vga_x,
  output logic [VY_W-1:0]                        vga_y,
  output logic [COLOR_W-1:0]                     vga_color,
  output logic                                   vga_plot
);

  localparam int GXW      = $clog2(GRID_W);
  localparam int GYW      = $clog2(GRID_H);
  localparam int TAW      = $clog2(TILE*TILE);
  localparam int DW       = $clog2(TILE+1);
  localparam int IW       = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int CW       = $clog2(READ_LAT+2);
  localparam int SCREEN_W = GRID_W*TILE;
  localparam int SCREEN_H = GRID_H*TILE;

  localparam logic [DW-1:0]   D_LAST   = DW'(TILE-1);
  localparam logic [VX_W-1:0] FX_LAST  = VX_W'(SCREEN_W-1);
  localparam logic [VY_W-1:0] FY_LAST  = VY_W'(SCREEN_H-1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_SPR-1);
  localparam logic [CW-1:0]   DC_LAST  = CW'(READ_LAT);

  // Pixel coordinates are formed one bit wider, then deliberately truncated.
  function automatic logic [VX_W-1:0] tile_px_x(input logic [GXW-1:0] g, input logic [DW-1:0] d);
    logic [8:0] w;
    w = 9'(g) * 9'(TILE) + 9'(d);
    return w[VX_W-1:0];
  endfunction

  function automatic logic [VY_W-1:0] tile_px_y(input logic [GYW-1:0] g, input logic [DW-1:0] d);
    logic [7:0] w;
    w = 8'(g) * 8'(TILE) + 8'(d);
    return w[VY_W-1:0];
  endfunction

  state_t state, state_d;

  logic               first_frame, fill_req;
  logic [IW-1:0]      idx;
  logic [DW-1:0]      dx, dy;
  logic [VX_W-1:0]    fx;
  logic [VY_W-1:0]    fy;
  logic [CW-1:0]      dcnt;
  logic [GXW-1:0]     cur_gx [NUM_SPR], prev_gx [NUM_SPR], in_gx [NUM_SPR], src_gx [NUM_SPR];
  logic [GYW-1:0]     cur_gy [NUM_SPR], prev_gy [NUM_SPR], in_gy [NUM_SPR], src_gy [NUM_SPR];
  logic [NUM_SPR-1:0] moved;
  logic               nm_found, tile_last;
  logic [IW-1:0]      nm_idx;

  // During LATCH the snapshot is not yet in cur[], so compare against the live inputs.
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      in_gx[i]  = spr_gx[i*GXW +: GXW];
      in_gy[i]  = spr_gy[i*GYW +: GYW];
      src_gx[i] = (state == LATCH) ? in_gx[i] : cur_gx[i];
      src_gy[i] = (state == LATCH) ? in_gy[i] : cur_gy[i];
      moved[i]  = (src_gx[i] != prev_gx[i]) || (src_gy[i] != prev_gy[i]);
    end
  end

  // Lowest-index moved sprite after the current one; lets ERASE skip still sprites with no gap.
  always_comb begin
    nm_found = 1'b0;
    nm_idx   = '0;
    for (int i = NUM_SPR-1; i >= 0; i--) begin
      if (moved[i] && ((state == LATCH) || (i > int'(idx)))) begin
        nm_found = 1'b1;
        nm_idx   = IW'(i);
      end
    end
  end

  assign tile_last = (dx == D_LAST) && (dy == D_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = LATCH;
      LATCH:   state_d = fill_req ? FILL : (nm_found ? ERASE : DRAW);
      FILL:    if (fx == FX_LAST && fy == FY_LAST) state_d = DRAW;
      ERASE:   if (tile_last && !nm_found) state_d = DRAW;
      DRAW:    if (tile_last && idx == IDX_LAST) state_d = DRAIN;
      DRAIN:   if (dcnt == DC_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state == LATCH) begin
      cur_gx <= in_gx;
      cur_gy <= in_gy;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_frame <= 1'b1;
      fill_req    <= 1'b0;
      idx         <= '0;
      dx          <= '0;
      dy          <= '0;
      fx          <= '0;
      fy          <= '0;
      dcnt        <= '0;
      done        <= 1'b0;
      for (int i = 0; i < NUM_SPR; i++) begin
        prev_gx[i] <= '0;
        prev_gy[i] <= '0;
      end
    end else begin
      done <= (state == DRAIN) && (dcnt == DC_LAST);
      case (state)
        IDLE: if (start) fill_req <= first_frame | force_fill;
        LATCH: begin
          fx  <= '0;
          fy  <= '0;
          dx  <= '0;
          dy  <= '0;
          idx <= nm_found ? nm_idx : '0;
        end
        FILL: begin
          if (fx == FX_LAST) begin
            fx <= '0;
            fy <= fy + 1'b1;
          end else begin
            fx <= fx + 1'b1;
          end
          if (fx == FX_LAST && fy == FY_LAST) begin
            first_frame <= 1'b0;
            idx         <= '0;
          end
        end
        ERASE, DRAW: begin
          if (dx == D_LAST) begin
            dx <= '0;
            dy <= (dy == D_LAST) ? '0 : dy + 1'b1;
          end else begin
            dx <= dx + 1'b1;
          end
          if (tile_last) begin
            if (state == ERASE) begin
              idx <= nm_found ? nm_idx : '0;
            end else begin
              idx <= idx + 1'b1;
              if (idx == IDX_LAST) begin
                prev_gx <= cur_gx;
                prev_gy <= cur_gy;
                dcnt    <= '0;
              end
            end
          end
        end
        DRAIN: dcnt <= dcnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // ---- stage p0: address issue ----
  logic            issue, vld_p0, sel_p0, flat_p0;
  logic [VX_W-1:0] x_p0;
  logic [VY_W-1:0] y_p0;
  logic [GXW-1:0]  gx_sel;
  logic [GYW-1:0]  gy_sel;

  always_comb begin
    issue   = (state == FILL) || (state == ERASE) || (state == DRAW);
    gx_sel  = (state == ERASE) ? prev_gx[idx] : cur_gx[idx];
    gy_sel  = (state == ERASE) ? prev_gy[idx] : cur_gy[idx];
    x_p0    = (state == FILL) ? fx : tile_px_x(gx_sel, dx);
    y_p0    = (state == FILL) ? fy : tile_px_y(gy_sel, dy);
    vld_p0  = issue;
    sel_p0  = (state == DRAW) && (idx == '0);
    flat_p0 = (state == DRAW) && (idx != '0);
    bg_x     = issue ? x_p0 : '0;
    bg_y     = issue ? y_p0 : '0;
    spr_addr = (state == DRAW) ? (TAW'(dy) * TAW'(TILE) + TAW'(dx)) : '0;
  end

  // ---- stage p1: ROM data arrives ----
  logic [VX_W-1:0]    x_p1;
  logic [VY_W-1:0]    y_p1;
  logic               vld_p1, sel_p1, flat_p1, key_hit;
  logic [COLOR_W-1:0] color_p1;

  renderer_pixel_pipe #(.READ_LAT(READ_LAT)) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .x_p0    (x_p0),
    .y_p0    (y_p0),
    .vld_p0  (vld_p0),
    .sel_p0  (sel_p0),
    .flat_p0 (flat_p0),
    .x_p1    (x_p1),
    .y_p1    (y_p1),
    .vld_p1  (vld_p1),
    .sel_p1  (sel_p1),
    .flat_p1 (flat_p1)
  );

  always_comb begin
    color_p1 = sel_p1 ? spr_color : (flat_p1 ? SPR_FLAT : bg_color);
`ifdef SPR_COLOR_KEY_EN
    key_hit  = (sel_p1 || flat_p1) && (color_p1 == SPR_KEY);
`else
    key_hit  = 1'b0;
`endif
  end

  // ---- stage p2: registered plot outputs ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_plot  <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
    end else begin
      vga_plot  <= vld_p1 && !key_hit;
      vga_x     <= x_p1;
      vga_y     <= y_p1;
      vga_color <= color_p1;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a frame-level reference model and per-plot scoreboard.
module tb_sprite_renderer;

  localparam int NUM_SPR = 4;
  localparam int TILE    = 5;
  localparam int RL      = 1;
`ifdef SPR_COLOR_KEY_EN
  localparam int KS = 1;
`else
  localparam int KS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset, start, force_fill;
  logic        busy, done;
  logic [19:0] spr_gx, spr_gy;
  logic [7:0]  bg_x;
  logic [6:0]  bg_y;
  logic [11:0] bg_color, spr_color;
  logic [4:0]  spr_addr;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [11:0] vga_color;
  logic        vga_plot;

  sprite_renderer #(.NUM_SPR(NUM_SPR), .TILE(TILE), .GRID_W(32), .GRID_H(24),
                    .READ_LAT(RL), .SPR_FLAT(12'hFFF)) dut (
    .clock(clock), .reset(reset), .start(start), .force_fill(force_fill),
    .busy(busy), .done(done), .spr_gx(spr_gx), .spr_gy(spr_gy),
    .bg_x(bg_x), .bg_y(bg_y), .bg_color(bg_color),
    .spr_addr(spr_addr), .spr_color(spr_color),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [11:0] bg_fn(input int x, input int y);
    return 12'((x*37 + y*101) ^ (y*16));
  endfunction

  function automatic logic [26:0] pk(input int x, input int y, input logic [11:0] c);
    return {8'(x), 7'(y), c};
  endfunction

  logic [11:0] spr_rom [25];
  logic [11:0] bg_dl [RL], spr_dl [RL];

  always @(posedge clock) begin
    bg_dl[0]  <= bg_fn(int'(bg_x), int'(bg_y));
    spr_dl[0] <= spr_rom[spr_addr];
    for (int k = 1; k < RL; k++) begin
      bg_dl[k]  <= bg_dl[k-1];
      spr_dl[k] <= spr_dl[k-1];
    end
  end
  assign bg_color  = bg_dl[RL-1];
  assign spr_color = spr_dl[RL-1];

  // Reference model: what a frame must plot, in order.
  logic [26:0] exp_q[$];
  logic [26:0] log_q[$];
  int  m_px [NUM_SPR];
  int  m_py [NUM_SPR];
  bit  m_first = 1'b1;

  task automatic model_reset();
    exp_q.delete();
    m_first = 1'b1;
    for (int i = 0; i < NUM_SPR; i++) begin m_px[i] = 0; m_py[i] = 0; end
  endtask

  task automatic model_build(input logic ff, output int exp_el);
    int cx[NUM_SPR];
    int cy[NUM_SPR];
    int n = 0;
    logic [11:0] c;
    for (int i = 0; i < NUM_SPR; i++) begin
      cx[i] = int'(spr_gx[i*5 +: 5]);
      cy[i] = int'(spr_gy[i*5 +: 5]);
    end
    if (m_first || ff) begin
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++) exp_q.push_back(pk(x, y, bg_fn(x, y)));
      n = 19200;
      m_first = 1'b0;
    end else begin
      for (int i = 0; i < NUM_SPR; i++)
        if (cx[i] != m_px[i] || cy[i] != m_py[i]) begin
          for (int dy = 0; dy < TILE; dy++)
            for (int dx = 0; dx < TILE; dx++)
              exp_q.push_back(pk(m_px[i]*TILE+dx, m_py[i]*TILE+dy,
                                 bg_fn(m_px[i]*TILE+dx, m_py[i]*TILE+dy)));
          n += TILE*TILE;
        end
    end
    for (int i = 0; i < NUM_SPR; i++)
      for (int dy = 0; dy < TILE; dy++)
        for (int dx = 0; dx < TILE; dx++) begin
          c = (i == 0) ? spr_rom[dy*TILE+dx] : 12'hFFF;
          if (!(KS == 1 && c == 12'h000))
            exp_q.push_back(pk(cx[i]*TILE+dx, cy[i]*TILE+dy, c));
        end
    for (int i = 0; i < NUM_SPR; i++) begin m_px[i] = cx[i]; m_py[i] = cy[i]; end
    exp_el = 2 + n + NUM_SPR*TILE*TILE + RL + 1;
  endtask

  // Scoreboard: every plot must be the next expected pixel.
  always @(negedge clock) begin
    if (!reset && vga_plot) begin
      log_q.push_back({vga_x, vga_y, vga_color});
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_plot actual=%0h required=none", {vga_x, vga_y, vga_color});
      end else begin
        chk("plot", {5'b0, vga_x, vga_y, vga_color}, {5'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic set_pos(input int i, input int gx, input int gy);
    spr_gx[i*5 +: 5] = 5'(gx);
    spr_gy[i*5 +: 5] = 5'(gy);
  endtask

  task automatic run_frame(input string nm, input logic ff, input int pulse_at, output int elapsed);
    int exp_el, e0;
    bit got = 1'b0;
    elapsed = -1;
    log_q.delete();
    model_build(ff, exp_el);
    @(negedge clock);
    force_fill = ff;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    force_fill = 1'b0;
    e0 = cyc;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    for (int n = 0; n < 30000; n++) begin
      @(negedge clock);
      if (n == pulse_at) begin
        start = 1'b1;
        spr_gx = spr_gx ^ 20'h0A5A5;
      end else if (n == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        elapsed = cyc - e0 + 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_cycles"}, 32'(elapsed), 32'(exp_el));
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
  endtask

  int el, extra;

  initial begin
    for (int i = 0; i < 25; i++) spr_rom[i] = 12'(i*151 + 7);
    spr_rom[12] = 12'h000;
    reset = 1'b1; start = 1'b0; force_fill = 1'b0; spr_gx = '0; spr_gy = '0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_vga", {5'b0, vga_x, vga_y, vga_color}, 0);
    chk("rst_addr", {12'b0, bg_x, bg_y, spr_addr}, 0);
    reset = 1'b0;

    // 1: first frame, full fill
    for (int i = 0; i < NUM_SPR; i++) set_pos(i, i, 0);
    run_frame("t1", 1'b0, -1, el);
    chk("t1_total", 32'(el), 32'd19304);
    chk("t1_plots", 32'(log_q.size()), 32'(19300 - KS));
    chk("t1_px0", 32'(log_q[0]), 32'(pk(0, 0, bg_fn(0, 0))));
    chk("t1_px159", 32'(log_q[159]), 32'(pk(159, 0, bg_fn(159, 0))));
    chk("t1_px160", 32'(log_q[160]), 32'(pk(0, 1, bg_fn(0, 1))));
    chk("t1_fill_end", 32'(log_q[19199]), 32'(pk(159, 119, bg_fn(159, 119))));
    chk("t1_spr0", 32'(log_q[19200]), 32'(pk(0, 0, spr_rom[0])));
    chk("t1_spr1", 32'(log_q[19225 - KS]), 32'(pk(5, 0, 12'hFFF)));

    // 2: nothing moved, draw only
    run_frame("t2", 1'b0, -1, el);
    chk("t2_total", 32'(el), 32'd104);
    chk("t2_plots", 32'(log_q.size()), 32'(100 - KS));
    if (KS == 1) chk("t2_key", 32'(log_q[12]), 32'(pk(3, 2, spr_rom[13])));
    else         chk("t2_key", 32'(log_q[12]), 32'(pk(2, 2, 12'h000)));

    // 3: sprite 2 moves to (5,7)
    set_pos(2, 5, 7);
    run_frame("t3", 1'b0, -1, el);
    chk("t3_total", 32'(el), 32'd129);
    chk("t3_erase0", 32'(log_q[0]), 32'(pk(10, 0, bg_fn(10, 0))));
    chk("t3_erase24", 32'(log_q[24]), 32'(pk(14, 4, bg_fn(14, 4))));
    chk("t3_spr2_first", 32'(log_q[75 - KS]), 32'(pk(25, 35, 12'hFFF)));
    chk("t3_spr2_last", 32'(log_q[99 - KS]), 32'(pk(29, 39, 12'hFFF)));

    // 4: reset mid-fill, next frame must fill again
    log_q.delete();
    model_build(1'b1, el);
    @(negedge clock); force_fill = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0; force_fill = 1'b0;
    repeat (499) @(negedge clock);
    chk("t4_plot_before", 32'(vga_plot), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t4_plot_cleared", 32'(vga_plot), 32'd0);
    chk("t4_busy_cleared", 32'(busy), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    run_frame("t4", 1'b0, -1, el);
    chk("t4_total", 32'(el), 32'd19304);

    // 5: force_fill on an incremental frame, stray start and input change mid-frame
    run_frame("t5", 1'b1, 300, el);
    chk("t5_total", 32'(el), 32'd19304);
    chk("t5_plots", 32'(log_q.size()), 32'(19300 - KS));
    extra = 0;
    repeat (60) begin
      @(negedge clock);
      if (done || busy) extra++;
    end
    chk("t5_no_extra_frame", 32'(extra), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
